vga_timing_gen: RTL

//  Generates 640x480@60 VGA raster timing: hCount/vCount, bright, hSync/vSync, plus pixel and frame strobes.

---
 rtl/vga_timing_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60 VGA raster timing source. Produces the scan position
// (hCount/vCount), the visible-area flag, active-low syncs, a pixel strobe
// and a once-per-frame strobe for game-state updates.
// Optional feature: define VGA_FRAME_COUNT_EN to build a 16-bit
// frames-completed counter; without it frame_count is constant zero.
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 784,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 515
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        hSync,
  output logic        vSync,
  output logic        pix_tick,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_L  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_L  = 10'(V_SYNC);
  localparam logic [9:0] H_DISP_S  = 10'(H_DISP_START);
  localparam logic [9:0] H_DISP_E  = 10'(H_DISP_END);
  localparam logic [9:0] V_DISP_S  = 10'(V_DISP_START);
  localparam logic [9:0] V_DISP_E  = 10'(V_DISP_END);

  logic [DIV_W-1:0] div;
  logic             advance;
  logic             frame_wrap;
  logic [9:0]       next_h;
  logic [9:0]       next_v;
  logic             next_hsync;
  logic             next_vsync;
  logic             next_bright;

  // Decide where the counters land on this edge and decode that position,
  // so the registered decodes line up with the registered counts.
  always_comb begin
    advance    = (div == DIV_LAST);
    frame_wrap = advance && (hCount == H_LAST) && (vCount == V_LAST);
    next_h     = hCount;
    next_v     = vCount;
    if (advance) begin
      if (hCount == H_LAST) begin
        next_h = '0;
        next_v = (vCount == V_LAST) ? '0 : vCount + 10'd1;
      end else begin
        next_h = hCount + 10'd1;
      end
    end
    next_hsync  = (next_h >= H_SYNC_L);
    next_vsync  = (next_v >= V_SYNC_L);
    next_bright = (next_h >= H_DISP_S) && (next_h < H_DISP_E) &&
                  (next_v >= V_DISP_S) && (next_v < V_DISP_E);
  end

  // Pixel divider, scan counters and the two strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div        <= '0;
      hCount     <= '0;
      vCount     <= '0;
      pix_tick   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div        <= advance ? '0 : div + DIV_ONE;
      hCount     <= next_h;
      vCount     <= next_v;
      pix_tick   <= advance;
      frame_tick <= frame_wrap;
    end
  end

  // Registered sync and visible-area decodes of the upcoming position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hSync  <= 1'b0;
      vSync  <= 1'b0;
      bright <= 1'b0;
    end else begin
      hSync  <= next_hsync;
      vSync  <= next_vsync;
      bright <= next_bright;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Count completed frames, bumping on the same edge as frame_tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_count <= '0;
    end else if (frame_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign frame_count = 16'd0;
`endif

endmodule
